// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, write FSM states and address helpers for fb_pixel_writer
package fb_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_DONE} wr_state_t;

  // y*640 + x built from two shifts so no multiplier is needed
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [ADDR_W-1:0] pix);
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    x_ext = {{(ADDR_W-X_W){1'b0}}, pix[ADDR_W-1 -: X_W]};
    y_ext = {{(ADDR_W-Y_W){1'b0}}, pix[Y_W-1:0]};
    return (y_ext << 9) + (y_ext << 7) + x_ext;
  endfunction

  function automatic logic in_bounds(input logic [ADDR_W-1:0] pix);
    return (32'(pix[ADDR_W-1 -: X_W]) < H_RES) && (32'(pix[Y_W-1:0]) < V_RES);
  endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// rtl/fb_pixel_writer_if.sv - pixel stream and SRAM write bus for fb_pixel_writer
interface fb_pixel_writer_if
  import fb_pkg::*;
#(
  parameter int COLOR_W = 8
);
  logic [ADDR_W-1:0]  pix_addr;
  logic               pix_valid;
  logic               pix_stop;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_data;
  logic               mem_we;
  logic               mem_ack;

  modport master (
    output pix_addr, pix_valid, mem_ack,
    input  pix_stop, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  pix_addr, pix_valid, mem_ack,
    output pix_stop, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/fb_pixel_writer_pix_fifo.sv
// rtl/fb_pixel_writer_pix_fifo.sv - synchronous pixel FIFO, first-word-fall-through read
module pix_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still takes a push when the same cycle frees a slot
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - dedupes pixel addresses, queues them and writes SRAM; FB_CLIP_EN drops off-screen pixels
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prim_start,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               line_done,
  output logic               wr_done,
  output logic               err_ovf,
  fb_pixel_writer_if.slave   bus
);
  localparam int EW = ADDR_W + COLOR_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [COLOR_W-1:0] color_q;
  logic [ADDR_W-1:0]  last_addr;
  logic               last_valid;
  logic               in_range;
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic [EW-1:0]      fifo_din;
  logic [EW-1:0]      fifo_dout;
  logic               line_done_q;
  logic               done_pend;
  logic               done_clr;
  wr_state_t          state;
  wr_state_t          state_nxt;

`ifdef FB_CLIP_EN
  assign in_range = in_bounds(bus.pix_addr);
`else
  assign in_range = 1'b1;
`endif

  assign accept    = bus.pix_valid && in_range && !(last_valid && (bus.pix_addr == last_addr));
  assign push      = accept && (!full || pop);
  assign count_nxt = count + CW'(push) - CW'(pop);
  // colour travels with each entry so a new primitive cannot recolour queued pixels
  assign fifo_din  = {lin_addr(bus.pix_addr), color_q};

  pix_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q      <= '0;
      last_addr    <= '0;
      last_valid   <= 1'b0;
      err_ovf      <= 1'b0;
      bus.pix_stop <= 1'b0;
      line_done_q  <= 1'b0;
      done_pend    <= 1'b0;
    end else begin
      line_done_q  <= line_done;
      if (prim_start) begin
        color_q    <= color_in;
        last_valid <= 1'b0;
        err_ovf    <= 1'b0;
      end
      if (push) begin
        last_valid <= 1'b1;
        last_addr  <= bus.pix_addr;
      end
      if (accept && !push) err_ovf <= 1'b1;
      // two slots of slack absorb the generator's reaction delay
      bus.pix_stop <= (count_nxt >= CW'(DEPTH - 2));
      if (done_clr) done_pend <= 1'b0;
      if (line_done && !line_done_q) done_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= W_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr_done   = 1'b0;
    done_clr  = 1'b0;
    case (state)
      W_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = W_REQ;
        end else if (done_pend) begin
          state_nxt = W_DONE;
        end
      end
      W_REQ: begin
        if (bus.mem_ack) begin
          if (!empty)         pop       = 1'b1;
          else if (done_pend) state_nxt = W_DONE;
          else                state_nxt = W_IDLE;
        end
      end
      W_DONE: begin
        wr_done   = 1'b1;
        done_clr  = 1'b1;
        state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  assign bus.mem_we = (state == W_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
    end else if (pop) begin
      {bus.mem_addr, bus.mem_data} <= fifo_dout;
    end
  end
endmodule
